// File: rtl/microwave_cook_timer.sv
// rtl/microwave_cook_timer.sv - heating-side cook timer, heater enable and end-of-cook beeper
//
// Ports:
//   clk          system clock
//   sys_reset_n  asynchronous active-low reset
//   States       controller state vector {Start, Close, Heat, Error}
//   time_load    one-cycle strobe, captures time_in into the preset (IDLE only)
//   time_in      cook time in seconds
//   done         cook complete, held while the controller stays in Close+Heat
//   heater_on    heating element enable
//   busy         high while cooking or waiting for the done handshake
//   remaining    seconds left in the current cook
//   beep         end-of-cook beeper, BEEP_CYCLES clocks long
//
// Optional feature macro: MICROWAVE_RESUME_EN (an aborted cook keeps its
// remaining time and resumes from it on the next start).

module microwave_cook_timer #(
  parameter int TIME_W      = 8,
  parameter int TICK_DIV    = 100,
  parameter int BEEP_CYCLES = 50
) (
  input  logic              clk,
  input  logic              sys_reset_n,
  input  logic [3:0]        States,
  input  logic              time_load,
  input  logic [TIME_W-1:0] time_in,
  output logic              done,
  output logic              heater_on,
  output logic              busy,
  output logic [TIME_W-1:0] remaining,
  output logic              beep
);

  localparam int PS_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BC_W        = (BEEP_CYCLES > 0) ? $clog2(BEEP_CYCLES + 1) : 1;
  localparam int BEEP_LOAD_I = (BEEP_CYCLES > 0) ? BEEP_CYCLES - 1 : 0;

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [BC_W-1:0] BEEP_LOAD = BC_W'(BEEP_LOAD_I);
  localparam logic            BEEP_EN   = (BEEP_CYCLES > 0);

  // Controller encodings this block reacts to.
  localparam logic [3:0] ST_START = 4'b1110;  // Start+Close+Heat
  localparam logic [3:0] ST_HEAT  = 4'b0110;  // Close+Heat

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COOK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TIME_W-1:0] preset, preset_nxt;
  logic [TIME_W-1:0] remaining_nxt;
  logic [PS_W-1:0]   prescaler, prescaler_nxt;
  logic [BC_W-1:0]   beep_cnt, beep_cnt_nxt;
  logic              done_nxt, heater_nxt, busy_nxt, beep_nxt;

  logic st_run;      // States keeps the cook going
  logic tick;        // prescaler is about to wrap: one second elapsed
  logic enter_done;  // cook finished on this edge
  logic unsafe;      // door open or error flagged

  assign st_run = (States == ST_START) || (States == ST_HEAT);
  assign tick   = (prescaler == PS_LAST);
  assign unsafe = States[0] || !States[2];

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state     <= IDLE;
      preset    <= '0;
      remaining <= '0;
      prescaler <= '0;
      beep_cnt  <= '0;
      done      <= 1'b0;
      heater_on <= 1'b0;
      busy      <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state     <= state_nxt;
      preset    <= preset_nxt;
      remaining <= remaining_nxt;
      prescaler <= prescaler_nxt;
      beep_cnt  <= beep_cnt_nxt;
      done      <= done_nxt;
      heater_on <= heater_nxt;
      busy      <= busy_nxt;
      beep      <= beep_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    preset_nxt    = preset;
    remaining_nxt = remaining;
    prescaler_nxt = prescaler;
    beep_cnt_nxt  = beep_cnt;
    done_nxt      = done;
    heater_nxt    = heater_on;
    busy_nxt      = busy;
    beep_nxt      = beep;
    enter_done    = 1'b0;

    // Beeper runs on its own so it keeps sounding after the FSM returns to IDLE.
    if (beep) begin
      if (beep_cnt == '0) begin
        beep_nxt = 1'b0;
      end else begin
        beep_cnt_nxt = beep_cnt - BC_W'(1);
      end
    end

    case (state)
      IDLE: begin
        // Start takes priority over a load on the same edge: the old preset is used.
        if (States == ST_START) begin
          state_nxt     = COOK;
          prescaler_nxt = '0;
          heater_nxt    = 1'b1;
          busy_nxt      = 1'b1;
`ifdef MICROWAVE_RESUME_EN
          remaining_nxt = (remaining != '0) ? remaining : preset;
`else
          remaining_nxt = preset;
`endif
        end else if (time_load) begin
          preset_nxt = time_in;
`ifdef MICROWAVE_RESUME_EN
          remaining_nxt = '0;
`endif
        end
      end

      COOK: begin
        // Abort is checked first so it wins over a coincident final tick.
        if (!st_run) begin
          state_nxt     = IDLE;
          heater_nxt    = 1'b0;
          busy_nxt      = 1'b0;
          prescaler_nxt = '0;
`ifndef MICROWAVE_RESUME_EN
          remaining_nxt = '0;
`endif
        end else if (remaining == '0) begin
          // Zero-length cook: finish on the first edge, no tick counted.
          enter_done = 1'b1;
        end else if (tick) begin
          prescaler_nxt = '0;
          remaining_nxt = remaining - TIME_W'(1);
          if (remaining == TIME_W'(1)) begin
            enter_done = 1'b1;
          end
        end else begin
          prescaler_nxt = prescaler + PS_W'(1);
        end
      end

      DONE: begin
        if (States != ST_HEAT) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt  = IDLE;
        done_nxt   = 1'b0;
        heater_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase

    if (enter_done) begin
      state_nxt    = DONE;
      done_nxt     = 1'b1;
      heater_nxt   = 1'b0;
      beep_nxt     = BEEP_EN;
      beep_cnt_nxt = BEEP_LOAD;
    end

    // Heater interlock overrides everything else.
    if (unsafe) begin
      heater_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_microwave_cook_timer.sv
// tb/tb_microwave_cook_timer.sv - self-checking bench for microwave_cook_timer

module tb_microwave_cook_timer;

  localparam int TW = 8;
  localparam int TD = 4;
  localparam int BC = 10;
`ifdef MICROWAVE_RESUME_EN
  localparam bit RESUME = 1'b1;
`else
  localparam bit RESUME = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [3:0]    States    = 4'b0000;
  logic          time_load = 1'b0;
  logic [TW-1:0] time_in   = '0;
  logic          done, heater_on, busy, beep;
  logic [TW-1:0] remaining;

  int n_cmp = 0;
  int n_err = 0;

  microwave_cook_timer #(
    .TIME_W(TW),
    .TICK_DIV(TD),
    .BEEP_CYCLES(BC)
  ) dut (
    .clk(clk),
    .sys_reset_n(rst_n),
    .States(States),
    .time_load(time_load),
    .time_in(time_in),
    .done(done),
    .heater_on(heater_on),
    .busy(busy),
    .remaining(remaining),
    .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 cooking, 2 finished. Remaining time is
  // derived from the number of cooking edges elapsed, not from a prescaler.
  int m_mode     = 0;
  int m_load     = 0;
  int m_elapsed  = 0;
  int m_preset   = 0;
  int m_retained = 0;
  int m_beep     = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_load = 0; m_elapsed = 0;
        m_preset = 0; m_retained = 0; m_beep = 0;
      end else begin
        if (m_beep > 0) m_beep--;
        case (m_mode)
          0: begin
            if (States == 4'b1110) begin
              m_mode    = 1;
              m_load    = (RESUME && m_retained != 0) ? m_retained : m_preset;
              m_elapsed = 0;
            end else if (time_load) begin
              m_preset   = int'(time_in);
              m_retained = 0;
            end
          end
          1: begin
            if (States == 4'b1110 || States == 4'b0110) begin
              if (m_load == 0) begin
                m_mode = 2; m_beep = BC;
              end else begin
                m_elapsed++;
                if (m_elapsed == TD * m_load) begin
                  m_mode = 2; m_beep = BC;
                end
              end
            end else begin
              m_mode     = 0;
              m_retained = RESUME ? (m_load - m_elapsed / TD) : 0;
            end
          end
          default: begin
            if (States != 4'b0110) begin
              m_mode = 0; m_retained = 0;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int exp_rem;
    forever begin
      @(negedge clk);
      exp_rem = (m_mode == 1) ? (m_load - m_elapsed / TD) :
                (m_mode == 2) ? 0 : m_retained;
      check("m_done",      int'(done),      int'(m_mode == 2));
      check("m_heater_on", int'(heater_on), int'(m_mode == 1));
      check("m_busy",      int'(busy),      int'(m_mode != 0));
      check("m_beep",      int'(beep),      int'(m_beep > 0));
      check("m_remaining", int'(remaining), exp_rem);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    cyc(3);
    check("rst_done", int'(done), 0);
    check("rst_heater", int'(heater_on), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_beep", int'(beep), 0);
    check("rst_remaining", int'(remaining), 0);
    rst_n = 1'b1;

    // 1: preset 3, full cook
    cyc(1); time_load = 1'b1; time_in = 8'd3;
    cyc(1); time_load = 1'b0; States = 4'b1100;
    cyc(1); States = 4'b1110;
    cyc(1);
    check("s1_heater_entry", int'(heater_on), 1);
    check("s1_busy_entry", int'(busy), 1);
    check("s1_rem_entry", int'(remaining), 3);
    States = 4'b0110;
    cyc(3); check("s1_rem_n3", int'(remaining), 3);
    cyc(1); check("s1_rem_n4", int'(remaining), 2);
    cyc(7);
    check("s1_done_n11", int'(done), 0);
    check("s1_rem_n11", int'(remaining), 1);
    cyc(1);
    check("s1_done_n12", int'(done), 1);
    check("s1_heater_n12", int'(heater_on), 0);
    check("s1_beep_n12", int'(beep), 1);

    // 2: handshake back to IDLE, beep continues
    cyc(2);
    check("s2_done_held", int'(done), 1);
    States = 4'b0100;
    cyc(1);
    check("s2_done_clr", int'(done), 0);
    check("s2_busy_clr", int'(busy), 0);
    check("s2_beep_idle", int'(beep), 1);
    cyc(6); check("s2_beep_last", int'(beep), 1);
    cyc(1); check("s2_beep_off", int'(beep), 0);

    // 3: abort after 9 cycles, then restart
    time_load = 1'b1; time_in = 8'd5;
    cyc(1); time_load = 1'b0; States = 4'b1110;
    cyc(1); States = 4'b0110;
    cyc(9);
    check("s3_rem_n9", int'(remaining), 3);
    States = 4'b0000;
    cyc(1);
    check("s3_heater_abort", int'(heater_on), 0);
    check("s3_done_abort", int'(done), 0);
    check("s3_rem_abort", int'(remaining), RESUME ? 3 : 0);
    States = 4'b1110;
    cyc(1); States = 4'b0110;
    k = 0;
    while (!done && k < 100) begin
      cyc(1);
      k++;
    end
    check("s3_restart_latency", k, RESUME ? 12 : 20);
    States = 4'b0100;
    cyc(1);

    // 4: zero preset
    time_load = 1'b1; time_in = 8'd0;
    cyc(1); time_load = 1'b0; States = 4'b1110;
    cyc(1);
    check("s4_heater_entry", int'(heater_on), 1);
    check("s4_done_entry", int'(done), 0);
    States = 4'b0110;
    cyc(1);
    check("s4_done", int'(done), 1);
    check("s4_heater_off", int'(heater_on), 0);
    States = 4'b0100;
    cyc(1);
    check("s4_done_clr", int'(done), 0);

    // 5: error during cook
    time_load = 1'b1; time_in = 8'd2;
    cyc(1); time_load = 1'b0; States = 4'b1110;
    cyc(1); States = 4'b0110;
    cyc(2); States = 4'b1101;
    cyc(1);
    check("s5_heater_err", int'(heater_on), 0);
    check("s5_busy_err", int'(busy), 0);
    check("s5_done_err", int'(done), 0);
    cyc(1);
    check("s5_done_after", int'(done), 0);
    States = 4'b0100;

    // 6: asynchronous reset mid-cook, then loads during COOK are ignored
    time_load = 1'b1; time_in = 8'd6;
    cyc(1); time_load = 1'b0; States = 4'b1110;
    cyc(1); States = 4'b0110;
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_heater", int'(heater_on), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_done", int'(done), 0);
    check("s6_rst_beep", int'(beep), 0);
    check("s6_rst_remaining", int'(remaining), 0);
    cyc(1); rst_n = 1'b1; States = 4'b0100;
    cyc(1); time_load = 1'b1; time_in = 8'd2;
    cyc(1); time_load = 1'b1; time_in = 8'd7; States = 4'b1110;
    cyc(1);
    check("s6_rem_entry", int'(remaining), 2);
    time_load = 1'b1; time_in = 8'd9; States = 4'b0110;
    cyc(1); time_load = 1'b0;
    cyc(6);
    check("s6_done_n7", int'(done), 0);
    check("s6_rem_n7", int'(remaining), 1);
    cyc(1);
    check("s6_done_n8", int'(done), 1);
    States = 4'b0100;
    cyc(1);
    check("s6_busy_idle", int'(busy), 0);
    States = 4'b1110;
    cyc(1);
    check("s6_preset_kept", int'(remaining), 2);
    States = 4'b0000;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/microwave_cook_timer.md
Name: microwave_cook_timer

Overview:
- Heating-side responder for the microwave controller FSM. Consumes the controller's 4-bit States vector {Start, Close, Heat, Error}, drives the heater, and counts down the programmed cook time.
- Returns the level `done` signal that moves the controller from 6 (Close+Heat) back to 4 (Close).
- Also owns the cook-time preset register and the end-of-cook beeper.

Parameters:
- TIME_W, 8, width of cook-time preset and remaining count (seconds).
- TICK_DIV, 100, clk cycles per one-second tick; must be >= 2.
- BEEP_CYCLES, 50, length of the beep pulse after completion, in clk cycles.

Ports:
- clk  in  1  system clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- States  in  4  controller state {Start,Close,Heat,Error}, synchronous to clk.
- time_load  in  1  one-cycle strobe: capture time_in into preset.
- time_in  in  TIME_W  cook time in seconds.
- done  out  1  cook complete; level, held per handshake below.
- heater_on  out  1  heating element enable.
- busy  out  1  high in COOK or DONE.
- remaining  out  TIME_W  seconds left.
- beep  out  1  completion beeper.

Behaviour:
Reset:
- Asynchronous on sys_reset_n low; releases on the next clk edge.
- Outputs on reset: done=0, heater_on=0, busy=0, beep=0.
- Registers on reset: remaining=0, preset=0, prescaler=0, FSM=IDLE.
- A reset mid-cook aborts immediately.

Preset:
- time_load is honoured only in IDLE; preset<=time_in on that edge.
- time_load is ignored in COOK and DONE.

FSM states: IDLE, COOK, DONE. All outputs are registered.
- IDLE -> COOK: on an edge sampling States==4'b1110. Same edge: remaining<=preset, prescaler<=0, heater_on<=1, busy<=1.
- COOK, normal counting:
  - Stays in COOK while States is 4'b1110 or 4'b0110.
  - prescaler counts 0..TICK_DIV-1 and wraps.
  - Each wrap decrements remaining.
- COOK -> DONE: when a wrap takes remaining from 1 to 0. Same edge: done<=1, heater_on<=0, beep<=1, beep counter loaded.
  - Resulting latency: done rises exactly TICK_DIV*preset cycles after the COOK entry edge.
- COOK, zero preset: with preset==0, COOK -> DONE on the first edge after entry, with no tick counted.
- COOK -> IDLE (abort): on any other States value, e.g. 4'b0000 door open or Error bit set.
  - Same edge: heater_on<=0, busy<=0, remaining<=0, no done, no beep.
- DONE:
  - done is held high while States==4'b0110.
  - On the first edge sampling States!=4'b0110: done<=0, busy<=0, -> IDLE.
- Beep: high for exactly BEEP_CYCLES cycles from DONE entry. It is independent of the FSM and continues into IDLE. It is cleared only by reset or by expiry.

Safety:
- heater_on is forced to 0 on the edge after any sample with States[0]==1 (Error) or States[2]==0 (door open), regardless of FSM state.

Simultaneous events:
- Abort and final tick on the same edge: abort wins, no done.
- time_load on the IDLE->COOK edge: the load is ignored and the old preset is used.

remaining:
- Never underflows; it saturates at 0.

Optional Feature:
- Macro: MICROWAVE_RESUME_EN.
- Defined:
  - An abort from COOK keeps the current remaining value instead of clearing it.
  - On the next IDLE->COOK entry, if remaining!=0, counting resumes from remaining with prescaler=0. Otherwise preset is loaded.
  - time_load in IDLE also clears any retained remaining.
- Undefined:
  - Abort clears remaining.
  - Every COOK entry reloads from preset.

Test Plan:
1. TICK_DIV=4, time_load with time_in=3, then States 1100->1110->0110 held -> heater_on=1 the edge after 1110; remaining steps 3,2,1,0 every 4 cycles; done=1 and heater_on=0 exactly 12 cycles after entry; beep high for BEEP_CYCLES.
2. Continue scenario 1 with States->0100 -> done=0 and busy=0 on the next edge; FSM=IDLE.
3. Preset 5, TICK_DIV=4, States->0000 after 9 cycles of COOK -> heater_on=0 next edge, no done.
   - remaining=0 without MICROWAVE_RESUME_EN.
   - With MICROWAVE_RESUME_EN: remaining=3; re-entry via 1110 yields done 12 cycles later.
4. Preset 0, States 1110->0110 -> done=1 one edge after COOK entry; heater pulses for one cycle only.
5. COOK with States forced to 4'b1101 (Error) -> heater_on=0 next edge, FSM=IDLE, done stays 0.
6. Assert sys_reset_n=0 asynchronously mid-COOK, between clock edges -> heater_on, busy, done, beep and remaining go to 0 immediately without a clock; after release, time_load during COOK is shown to be ignored.
